// File: rtl/banked_ram.sv
// Multi-bank synchronous RAM with a built-in zero-fill engine.
// Upper address bits select the bank; reads are registered and read-first.
module banked_ram #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned BANK_ADDR_WIDTH = 10,
  parameter int unsigned NUM_BANKS       = 4,
  parameter int unsigned BANK_SEL_WIDTH  = $clog2(NUM_BANKS)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_clr,
  input  logic                                      i_we,
  input  logic                                      i_re,
  input  logic [BANK_SEL_WIDTH+BANK_ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]                     i_in,
  output logic [DATA_WIDTH-1:0]                     o_out,
  output logic                                      o_out_valid,
  output logic                                      o_busy
);

  localparam int unsigned DEPTH = 2 ** BANK_ADDR_WIDTH;

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [BANK_ADDR_WIDTH-1:0]  r_ptr;
  logic [BANK_ADDR_WIDTH-1:0]  w_ptr_nxt;
  logic [DATA_WIDTH-1:0]       r_out;
  logic                        r_out_valid;

  logic                        w_ready;
  logic                        w_wr_acc;
  logic                        w_rd_acc;
  logic [BANK_SEL_WIDTH-1:0]   w_bank;
  logic [BANK_ADDR_WIDTH-1:0]  w_idx;
  logic [DATA_WIDTH-1:0]       w_bank_rd [NUM_BANKS];
  logic [DATA_WIDTH-1:0]       w_rd_data;

  assign w_bank   = i_addr[BANK_SEL_WIDTH+BANK_ADDR_WIDTH-1 -: BANK_SEL_WIDTH];
  assign w_idx    = i_addr[BANK_ADDR_WIDTH-1:0];
  assign w_ready  = (r_state == StReady);
  assign w_wr_acc = w_ready & i_we;
  assign w_rd_acc = w_ready & i_re;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      StClear: begin
        // Pointer wraps to 0 naturally on the last clear write.
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == {BANK_ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = StReady;
        end
      end
      StReady: begin
        if (i_clr) begin
          w_state_nxt = StClear;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = StClear;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StClear;
      r_ptr       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_out_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_out <= w_rd_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_sel;

    assign w_sel = (w_bank == BANK_SEL_WIDTH'(g));

    // No reset on the array: its zero state comes from the clear engine.
    always_ff @(posedge i_clk) begin
      if (!w_ready) begin
        r_mem[r_ptr] <= '0;
      end else if (w_wr_acc && w_sel) begin
        r_mem[w_idx] <= i_in;
      end
    end

    assign w_bank_rd[g] = r_mem[w_idx];
  end

  assign w_rd_data   = w_bank_rd[w_bank];
  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_busy      = ~w_ready;

endmodule

// File: doc/banked_ram.md
# banked_ram

Parameterised, multi-bank synchronous RAM, the next generation of the team's 4×1 KiB byte memory. Word width, per-bank depth and bank count are parameters. The upper address bits select the bank and the lower bits index within it. A built-in clear engine zero-fills every bank after reset or on request. Reads return a registered result with a `out_valid` strobe, and `out` holds its value between reads. The block sits between the CPU datapath and its load/store unit as the main data store.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `BANK_ADDR_WIDTH`, 10: index bits per bank; per-bank depth is 2^BANK_ADDR_WIDTH.
- `NUM_BANKS`, 4: bank count; must be a power of two, ≥2.
- `BANK_SEL_WIDTH`, derived as $clog2(NUM_BANKS): bank-select bits, occupying the address MSBs.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  single-cycle request to re-run the zero-fill; ignored while `busy`.
- `we`  in  1  write enable.
- `re`  in  1  read enable.
- `addr`  in  BANK_SEL_WIDTH+BANK_ADDR_WIDTH  address: {bank, index}.
- `in`  in  DATA_WIDTH  write data.
- `out`  out  DATA_WIDTH  registered read data.
- `out_valid`  out  1  high for one cycle when `out` carries a new read result.
- `busy`  out  1  high while the clear engine runs; all accesses are ignored.

## Operation
- The FSM has two states, `CLEAR` and `READY`. `rst` forces the FSM to `CLEAR`, clear pointer `ptr` to 0, `out` to 0, `out_valid` to 0 and `busy` to 1.
- In `CLEAR`, each cycle writes 0 to index `ptr` in all banks in parallel, then increments `ptr`.
  - When the write at `ptr` = 2^BANK_ADDR_WIDTH−1 completes, the FSM goes to `READY`, `busy` goes to 0 and `ptr` wraps to 0.
- In `READY`, `clr`=1 returns the FSM to `CLEAR` with `ptr`=0. A `we`/`re` in the same cycle as `clr` is still serviced.
- Write: when `we`=1 in `READY`, `in` is stored at bank `addr[MSBs]`, index `addr[BANK_ADDR_WIDTH-1:0]`. Only that bank is modified.
- Read: when `re`=1 in `READY`, the addressed word is registered to `out` and `out_valid` is 1 on the following cycle.
  - When `re`=0, or while `busy`, `out` holds its previous value. The bus is never tri-stated.
  - `out_valid` is 0 whenever no read was accepted on the previous edge.
- `we` and `re` may be asserted together:
  - Different address: both operations take place.
  - Same address: the read returns the old data (read-first), and the new data is visible to the next read.
- Accesses while `busy` are dropped silently. No memory change, no `out_valid`.
- Every address value is legal; there is no out-of-range case.
- Memory arrays are not reset directly. Their zero state comes only from the clear engine.

## Timing
- Read latency is 1 cycle: request on edge N, data and `out_valid` valid after edge N.
- Write latency is 1 cycle: data written on edge N, readable by a read accepted on edge N+1.
- After `rst` deasserts, `busy` stays 1 for exactly 2^BANK_ADDR_WIDTH rising edges (1024 cycles at defaults). It is 0 after the last clear edge, and the first access can be accepted on the next edge.
- After `clr` is accepted on edge N, `busy`=1 from edge N until 2^BANK_ADDR_WIDTH further edges have completed.
- Asserting `rst` mid-clear or mid-read forces the reset values immediately, without waiting for a clock edge. The clear restarts from `ptr`=0.
- Throughput is one read and one write per cycle in `READY`.

## Test plan
- Reset then idle: assert and release `rst` → `busy`=1 for 1024 cycles then 0, `out`=0, `out_valid`=0. Read any address → 0x00.
- Bank isolation: write 0xA5 to 0x005, 0x3C to 0x405, 0x77 to 0x805, 0xE1 to 0xC05. Read each address → matching value, `out_valid` one cycle after each `re`.
- Read-first collision: 0x123 holds 0x11. Assert `we`=1 with `in`=0x22 and `re`=1 at 0x123 in the same cycle → `out`=0x11. The next read of 0x123 → 0x22.
- Hold behaviour: after a read returning 0x5A, drive `re`=0 for 5 cycles → `out` stays 0x5A and `out_valid`=0.
- Clear request: fill several locations with non-zero data, pulse `clr` → `busy`=1 for 1024 cycles. Reads issued while busy give no `out_valid`. All locations read back 0x00 afterwards.
- Reset mid-clear: assert `rst` at `ptr`≈500 → outputs take reset values asynchronously. After release, `busy` lasts a full 1024 cycles again.
